// File: rtl/elastic_buffer_read_ctrl.sv
// Read-side controller for the RX elastic buffer: SKIP add/drop ppm compensation and under/overflow flags.
// Optional macro ELASTIC_BUFFER_RECENTER_EN re-centres the read pointer after an under/overflow pulse.
module elastic_buffer_read_ctrl #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDRESS_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] COMMA_SYMBOL = 10'h1BC,
    parameter logic [DATA_WIDTH-1:0] SKIP_SYMBOL = 10'h1A1,
    parameter int ADD_THRESHOLD = 5,
    parameter int DROP_THRESHOLD = 11,
    parameter int START_DELAY = 7
) (
    input  logic                     local_clock,
    input  logic                     local_reset,
    input  logic [ADDRESS_WIDTH:0]   write_pointer_sync,
    input  logic [DATA_WIDTH-1:0]    rd_data,
    input  logic [DATA_WIDTH-1:0]    rd_data_next,
    output logic [ADDRESS_WIDTH-1:0] read_address,
    output logic [ADDRESS_WIDTH-1:0] read_address_next,
    output logic [ADDRESS_WIDTH:0]   read_pointer_async,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     data_valid,
    output logic [ADDRESS_WIDTH:0]   fill_level,
    output logic                     skip_added,
    output logic                     skip_deleted,
    output logic                     underflow,
    output logic                     overflow
);

    localparam int PW = ADDRESS_WIDTH + 1;
    localparam logic [ADDRESS_WIDTH:0] DEPTH_LEVEL = {1'b1, {ADDRESS_WIDTH{1'b0}}};
    localparam logic [ADDRESS_WIDTH:0] HALF_DEPTH = {2'b01, {(ADDRESS_WIDTH-1){1'b0}}};
    localparam logic [ADDRESS_WIDTH:0] ADD_LEVEL = PW'(ADD_THRESHOLD);
    localparam logic [ADDRESS_WIDTH:0] DROP_LEVEL = PW'(DROP_THRESHOLD);
    localparam logic [7:0] START_COUNT = 8'(START_DELAY);

    typedef enum logic [1:0] {
        START,
        WAIT_COMMA,
        COMMA_SEEN,
        POST_ADD
    } state_t;

    state_t                   state;
    state_t                   state_next;
    logic [7:0]               counter;
    logic [7:0]               counter_next;
    logic [ADDRESS_WIDTH:0]   pointer_next;
    logic [DATA_WIDTH-1:0]    data_out_next;
    logic                     data_valid_next;
    logic                     skip_added_next;
    logic                     skip_deleted_next;
    logic                     underflow_next;
    logic                     overflow_next;
    logic                     advance;
    logic                     is_skip;
    logic                     add_ok;
    logic                     drop_ok;

    assign read_address      = read_pointer_async[ADDRESS_WIDTH-1:0];
    assign read_address_next = read_address + ADDRESS_WIDTH'(1);

    // Decisions use the registered fill level, one cycle stale by design.
    assign is_skip = (rd_data == SKIP_SYMBOL);
    assign add_ok  = (fill_level <= ADD_LEVEL);
    assign drop_ok = (fill_level >= DROP_LEVEL);

    always_comb begin
        state_next        = state;
        counter_next      = counter;
        pointer_next      = read_pointer_async;
        data_out_next     = data_out;
        data_valid_next   = data_valid;
        skip_added_next   = 1'b0;
        skip_deleted_next = 1'b0;
        advance           = 1'b0;

        case (state)
            START: begin
                counter_next = counter + 8'd1;
                if (counter + 8'd1 == START_COUNT) begin
                    data_valid_next = 1'b1;
                    state_next      = WAIT_COMMA;
                end
            end
            WAIT_COMMA: begin
                data_out_next = rd_data;
                pointer_next  = read_pointer_async + PW'(1);
                advance       = 1'b1;
                if (rd_data == COMMA_SYMBOL) begin
                    state_next = COMMA_SEEN;
                end
            end
            COMMA_SEEN: begin
                // Holding the pointer replays the SKIP; skipping two consumes it.
                if (is_skip && add_ok) begin
                    data_out_next   = SKIP_SYMBOL;
                    skip_added_next = 1'b1;
                    state_next      = POST_ADD;
                end else if (is_skip && drop_ok) begin
                    data_out_next     = rd_data_next;
                    pointer_next      = read_pointer_async + PW'(2);
                    advance           = 1'b1;
                    skip_deleted_next = 1'b1;
                    state_next        = WAIT_COMMA;
                end else begin
                    data_out_next = rd_data;
                    pointer_next  = read_pointer_async + PW'(1);
                    advance       = 1'b1;
                    state_next    = WAIT_COMMA;
                end
            end
            POST_ADD: begin
                data_out_next = rd_data;
                pointer_next  = read_pointer_async + PW'(1);
                advance       = 1'b1;
                state_next    = WAIT_COMMA;
            end
            default: begin
                state_next = START;
            end
        endcase

`ifdef ELASTIC_BUFFER_RECENTER_EN
        if (underflow || overflow) begin
            pointer_next      = write_pointer_sync - HALF_DEPTH;
            data_out_next     = data_out;
            data_valid_next   = 1'b0;
            counter_next      = 8'd0;
            skip_added_next   = 1'b0;
            skip_deleted_next = 1'b0;
            advance           = 1'b0;
            state_next        = START;
        end
`else
        // Without re-centring the flags are informational and the pointer free-runs.
        if (HALF_DEPTH == '0) begin
            pointer_next = read_pointer_async;
        end
`endif

        underflow_next = advance && (fill_level == '0);
        overflow_next  = (fill_level >= DEPTH_LEVEL);
    end

    always_ff @(posedge local_clock or negedge local_reset) begin
        if (!local_reset) begin
            state              <= START;
            counter            <= 8'd0;
            read_pointer_async <= '0;
            data_out           <= '0;
            data_valid         <= 1'b0;
            fill_level         <= '0;
            skip_added         <= 1'b0;
            skip_deleted       <= 1'b0;
            underflow          <= 1'b0;
            overflow           <= 1'b0;
        end else begin
            state              <= state_next;
            counter            <= counter_next;
            read_pointer_async <= pointer_next;
            data_out           <= data_out_next;
            data_valid         <= data_valid_next;
            fill_level         <= write_pointer_sync - read_pointer_async;
            skip_added         <= skip_added_next;
            skip_deleted       <= skip_deleted_next;
            underflow          <= underflow_next;
            overflow           <= overflow_next;
        end
    end

endmodule

// File: tb/tb_elastic_buffer_read_ctrl.sv
// Directed bench for elastic_buffer_read_ctrl: start delay, SKIP add/drop, pointer wrap, flags, mid-run reset.
module tb_elastic_buffer_read_ctrl;

    logic       local_clock = 1'b0;
    logic       local_reset = 1'b0;
    logic [4:0] write_pointer_sync = 5'd8;
    logic [9:0] rd_data;
    logic [9:0] rd_data_next;
    logic [3:0] read_address;
    logic [3:0] read_address_next;
    logic [4:0] read_pointer_async;
    logic [9:0] data_out;
    logic       data_valid;
    logic [4:0] fill_level;
    logic       skip_added;
    logic       skip_deleted;
    logic       underflow;
    logic       overflow;

    logic [9:0] mem [16];
    int checks = 0;
    int errors = 0;

    elastic_buffer_read_ctrl dut (
        .local_clock(local_clock),
        .local_reset(local_reset),
        .write_pointer_sync(write_pointer_sync),
        .rd_data(rd_data),
        .rd_data_next(rd_data_next),
        .read_address(read_address),
        .read_address_next(read_address_next),
        .read_pointer_async(read_pointer_async),
        .data_out(data_out),
        .data_valid(data_valid),
        .fill_level(fill_level),
        .skip_added(skip_added),
        .skip_deleted(skip_deleted),
        .underflow(underflow),
        .overflow(overflow)
    );

    assign rd_data      = mem[read_address];
    assign rd_data_next = mem[read_address_next];

    always #5 local_clock = ~local_clock;

    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(posedge local_clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetValues(input string prefix);
        checkOutput({prefix, "_data_out"}, int'(data_out), 0);
        checkOutput({prefix, "_data_valid"}, int'(data_valid), 0);
        checkOutput({prefix, "_rp"}, int'(read_pointer_async), 0);
        checkOutput({prefix, "_ra_next"}, int'(read_address_next), 1);
        checkOutput({prefix, "_fill"}, int'(fill_level), 0);
        checkOutput({prefix, "_flags"}, int'({skip_added, skip_deleted, underflow, overflow}), 0);
    endtask

    // Write pointer static at 8: pointer held 7 cycles, data_valid on cycle 7, first read on cycle 8.
    task automatic runStartDelay(input string prefix);
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(1);
            checkOutput($sformatf("%s_rp_c%0d", prefix, k), int'(read_pointer_async), 0);
            checkOutput($sformatf("%s_dv_c%0d", prefix, k), int'(data_valid), (k == 7) ? 1 : 0);
            checkOutput($sformatf("%s_fill_c%0d", prefix, k), int'(fill_level), 8);
        end
        applyStimulus(1);
        checkOutput({prefix, "_rp_c8"}, int'(read_pointer_async), 1);
        checkOutput({prefix, "_data_c8"}, int'(data_out), 'h040);
        checkOutput({prefix, "_dv_c8"}, int'(data_valid), 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 10'h040 + 10'(i);
        mem[2] = 10'h1BC;
        mem[3] = 10'h1A1;
        mem[4] = 10'h0D0;
        mem[7] = 10'h1BC;
        mem[8] = 10'h1A1;
        mem[9] = 10'h0D1;
        mem[13] = 10'h1BC;
        mem[14] = 10'h1A1;

        applyStimulus(2);
        checkResetValues("por");
        #2 local_reset = 1'b1;

        runStartDelay("start");
        write_pointer_sync = 5'd6;

        // ADD: COMMA at addr 2 read on cycle 10 with fill 4, SKIP replayed.
        applyStimulus(2);
        checkOutput("add_comma_data", int'(data_out), 'h1BC);
        checkOutput("add_comma_rp", int'(read_pointer_async), 3);
        checkOutput("add_fill", int'(fill_level), 4);
        applyStimulus(1);
        checkOutput("add_skip1_data", int'(data_out), 'h1A1);
        checkOutput("add_pulse", int'(skip_added), 1);
        checkOutput("add_stall_rp", int'(read_pointer_async), 3);
        applyStimulus(1);
        checkOutput("add_skip2_data", int'(data_out), 'h1A1);
        checkOutput("add_pulse_end", int'(skip_added), 0);
        checkOutput("add_resume_rp", int'(read_pointer_async), 4);
        applyStimulus(1);
        checkOutput("add_d0_data", int'(data_out), 'h0D0);
        checkOutput("add_d0_rp", int'(read_pointer_async), 5);
        write_pointer_sync = 5'd19;

        // DROP: COMMA at addr 7 with fill 12, SKIP at addr 8 removed.
        applyStimulus(3);
        checkOutput("drop_comma_data", int'(data_out), 'h1BC);
        checkOutput("drop_fill", int'(fill_level), 12);
        checkOutput("drop_comma_rp", int'(read_pointer_async), 8);
        applyStimulus(1);
        checkOutput("drop_d1_data", int'(data_out), 'h0D1);
        checkOutput("drop_pulse", int'(skip_deleted), 1);
        checkOutput("drop_jump_rp", int'(read_pointer_async), 10);
        checkOutput("drop_no_add", int'(skip_added), 0);
        applyStimulus(1);
        checkOutput("drop_pulse_end", int'(skip_deleted), 0);
        checkOutput("drop_next_rp", int'(read_pointer_async), 11);
        checkOutput("drop_next_data", int'(data_out), 'h04A);
        write_pointer_sync = 5'd21;

        // Mid-band fill 8: SKIP passes through unchanged.
        applyStimulus(3);
        checkOutput("mid_comma_data", int'(data_out), 'h1BC);
        checkOutput("mid_fill", int'(fill_level), 8);
        applyStimulus(1);
        checkOutput("mid_skip_data", int'(data_out), 'h1A1);
        checkOutput("mid_rp", int'(read_pointer_async), 15);
        checkOutput("mid_no_skip_flags", int'({skip_added, skip_deleted}), 0);

        for (int i = 0; i < 16; i++) mem[i] = 10'h040 + 10'(i);
        write_pointer_sync = 5'd28;
        applyStimulus(8);
        checkOutput("wrap_rp23", int'(read_pointer_async), 23);
        write_pointer_sync = 5'd2;
        applyStimulus(7);
        checkOutput("wrap_rp30", int'(read_pointer_async), 30);
        applyStimulus(1);
        checkOutput("wrap_fill_wp2_rp30", int'(fill_level), 4);
        checkOutput("wrap_rp31", int'(read_pointer_async), 31);
        checkOutput("wrap_ra15", int'(read_address), 15);
        checkOutput("wrap_ra_next0", int'(read_address_next), 0);
        checkOutput("wrap_data14", int'(data_out), 'h04E);
        applyStimulus(1);
        checkOutput("wrap_rp0", int'(read_pointer_async), 0);
        checkOutput("wrap_fill3", int'(fill_level), 3);
        checkOutput("wrap_ra_next1", int'(read_address_next), 1);
        checkOutput("wrap_data15", int'(data_out), 'h04F);

        // Overflow: fill 20 registered, pulse one cycle later.
        write_pointer_sync = 5'd20;
        applyStimulus(1);
        checkOutput("ovf_fill20", int'(fill_level), 20);
        checkOutput("ovf_not_yet", int'(overflow), 0);
        write_pointer_sync = 5'd8;
        applyStimulus(1);
        checkOutput("ovf_pulse", int'(overflow), 1);
        applyStimulus(1);
        checkOutput("ovf_pulse_end", int'(overflow), 0);
        checkOutput("ovf_rp3", int'(read_pointer_async), 3);

        // Underflow: write pointer frozen at 8 drains the buffer.
        applyStimulus(6);
        checkOutput("udf_fill0", int'(fill_level), 0);
        checkOutput("udf_not_yet", int'(underflow), 0);
        checkOutput("udf_rp9", int'(read_pointer_async), 9);
        applyStimulus(1);
        checkOutput("udf_pulse", int'(underflow), 1);
        checkOutput("udf_rp10", int'(read_pointer_async), 10);
        checkOutput("udf_fill31", int'(fill_level), 31);
        checkOutput("udf_dv_kept", int'(data_valid), 1);
        applyStimulus(1);
        checkOutput("udf_pulse_end", int'(underflow), 0);
        checkOutput("udf_wrap_ovf", int'(overflow), 1);
        checkOutput("udf_rp11", int'(read_pointer_async), 11);

        // Asynchronous reset mid-stream, then the start delay repeats.
        #2 local_reset = 1'b0;
        #1 checkResetValues("midrst");
        #1 local_reset = 1'b1;
        runStartDelay("restart");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
